dac_spi_tx: RTL and testbench

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_tx_pkg.sv | 37 +++
 rtl/dac_spi_tx_tick.sv | 25 ++
 rtl/dac_spi_tx.sv | 156 +++++++++++++++
 tb/tb_dac_spi_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the MCP49x1 SPI DAC transmitter: frame layout,
// control-bit positions and the frame FSM state encoding.
package dac_spi_tx_pkg;

   localparam int unsigned FRAME_W     = 16;
   localparam int unsigned DATA_W      = 10;
   localparam int unsigned SHIFT_TICKS = 32;
   localparam int unsigned BITCNT_W    = 5;

   localparam int unsigned BIT_AB   = 15;
   localparam int unsigned BIT_BUF  = 14;
   localparam int unsigned BIT_GA   = 13;
   localparam int unsigned BIT_SHDN = 12;
   localparam int unsigned DATA_LSB = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      LATCH = 2'd3
   } state_e;

   // Channel A, active (SHDN=1), sample left-justified above two don't-care bits.
   function automatic logic [FRAME_W-1:0] build_frame(input logic              buf_bit,
                                                      input logic              ga_bit,
                                                      input logic [DATA_W-1:0] data);
      logic [FRAME_W-1:0] w;
      w                     = '0;
      w[BIT_AB]             = 1'b0;
      w[BIT_BUF]            = buf_bit;
      w[BIT_GA]             = ga_bit;
      w[BIT_SHDN]           = 1'b1;
      w[DATA_LSB +: DATA_W] = data;
      return w;
   endfunction

endpackage

// File: rtl/dac_spi_tx_tick.sv
// Half-period tick generator: pulses every CLK_DIV cycles while enabled,
// and holds its count at zero while disabled.
module clk_tick_gen #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] cnt;

   assign tick = enable && (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n)       cnt <= '0;
      else if (!enable) cnt <= '0;
      else if (tick)    cnt <= '0;
      else              cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for an MCP49x1 DAC with a one-entry pending sample
// register, chip-select gap and LDAC latch pulse after every frame.
module dac_spi_tx
   import dac_spi_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV = 25,
   parameter logic        BUF     = 1'b0,
   parameter logic        GA_N    = 1'b1
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              dac_cs_n,
   output logic              dac_sck,
   output logic              dac_sdi,
   output logic              dac_ld_n,
   output logic              busy,
   output logic              overrun,
   output logic              frame_done
);

   state_e               state, state_nxt;
   logic [FRAME_W-1:0]   shreg, shreg_nxt;
   logic [BITCNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic                 pend_valid, pend_valid_nxt;
   logic [FRAME_W-1:0]   pend_word, pend_word_nxt;
   logic                 cs_n_nxt, sck_nxt, sdi_nxt, ld_n_nxt, busy_nxt, overrun_nxt;
   logic                 start;
   logic [FRAME_W-1:0]   start_word;
   logic [FRAME_W-1:0]   load_word;
   logic                 tick_en;
   logic                 tick;

   assign tick_en   = (state != IDLE);
   assign load_word = build_frame(BUF, GA_N, data_in);

   // Decoded from registered state: the LATCH tick is the last cycle of a frame.
   assign frame_done = (state == LATCH) && tick;

   clk_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .enable (tick_en),
      .tick   (tick)
   );

   always_comb begin
      state_nxt      = state;
      shreg_nxt      = shreg;
      bit_cnt_nxt    = bit_cnt;
      pend_valid_nxt = pend_valid;
      pend_word_nxt  = pend_word;
      cs_n_nxt       = dac_cs_n;
      sck_nxt        = dac_sck;
      sdi_nxt        = dac_sdi;
      ld_n_nxt       = dac_ld_n;
      busy_nxt       = busy;
      overrun_nxt    = overrun;
      start          = 1'b0;
      start_word     = '0;

      // Any load while a frame runs (including the LATCH exit cycle) goes to pending.
      if (load && (state != IDLE)) begin
         pend_valid_nxt = 1'b1;
         pend_word_nxt  = load_word;
         if (pend_valid) overrun_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (load) begin
               start      = 1'b1;
               start_word = load_word;
            end
         end
         SHIFT: begin
            if (tick) begin
               sck_nxt     = ~dac_sck;
               bit_cnt_nxt = bit_cnt + BITCNT_W'(1);
               if (dac_sck) begin
                  shreg_nxt = shreg << 1;
                  sdi_nxt   = shreg[FRAME_W-2];
               end
               if (bit_cnt == BITCNT_W'(SHIFT_TICKS - 1)) begin
                  state_nxt = GAP;
                  cs_n_nxt  = 1'b1;
                  sdi_nxt   = 1'b0;
               end
            end
         end
         GAP: begin
            if (tick) begin
               state_nxt = LATCH;
               ld_n_nxt  = 1'b0;
            end
         end
         LATCH: begin
            if (tick) begin
               ld_n_nxt = 1'b1;
               if (pend_valid_nxt) begin
                  start          = 1'b1;
                  start_word     = pend_word_nxt;
                  pend_valid_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (start) begin
         state_nxt   = SHIFT;
         shreg_nxt   = start_word;
         sdi_nxt     = start_word[FRAME_W-1];
         sck_nxt     = 1'b0;
         cs_n_nxt    = 1'b0;
         ld_n_nxt    = 1'b1;
         busy_nxt    = 1'b1;
         bit_cnt_nxt = '0;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         pend_valid <= 1'b0;
         pend_word  <= '0;
         dac_cs_n   <= 1'b1;
         dac_sck    <= 1'b0;
         dac_sdi    <= 1'b0;
         dac_ld_n   <= 1'b1;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         bit_cnt    <= bit_cnt_nxt;
         pend_valid <= pend_valid_nxt;
         pend_word  <= pend_word_nxt;
         dac_cs_n   <= cs_n_nxt;
         dac_sck    <= sck_nxt;
         dac_sdi    <= sdi_nxt;
         dac_ld_n   <= ld_n_nxt;
         busy       <= busy_nxt;
         overrun    <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: one instance at CLK_DIV=2 for directed
// frames, one at CLK_DIV=1 for a random sample stream.
module tb_dac_spi_tx;

   localparam int unsigned DIV0 = 2;
   localparam int unsigned DIV1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [9:0] data0, data1;
   logic       load0, load1;
   logic       cs_n0, sck0, sdi0, ld_n0, busy0, ovr0, fd0;
   logic       cs_n1, sck1, sdi1, ld_n1, busy1, ovr1, fd1;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] exp_q0[$];
   logic [15:0] exp_q1[$];

   dac_spi_tx #(.CLK_DIV(DIV0), .BUF(1'b0), .GA_N(1'b1)) u_dut0 (
      .sysclk(clk), .rst_n(rst_n), .data_in(data0), .load(load0),
      .dac_cs_n(cs_n0), .dac_sck(sck0), .dac_sdi(sdi0), .dac_ld_n(ld_n0),
      .busy(busy0), .overrun(ovr0), .frame_done(fd0));

   dac_spi_tx #(.CLK_DIV(DIV1), .BUF(1'b0), .GA_N(1'b1)) u_dut1 (
      .sysclk(clk), .rst_n(rst_n), .data_in(data1), .load(load1),
      .dac_cs_n(cs_n1), .dac_sck(sck1), .dac_sdi(sdi1), .dac_ld_n(ld_n1),
      .busy(busy1), .overrun(ovr1), .frame_done(fd1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // MCP49x1 word: A/B=0, BUF=0, GA_N=1, SHDN=1, sample, two zero bits.
   function automatic logic [15:0] model_word(input logic [9:0] d);
      return {1'b0, 1'b0, 1'b1, 1'b1, d, 2'b00};
   endfunction

   // Serial capture and frame statistics, instance 0.
   int          bits0 = 0, run0 = 0, last_run0 = 0, ld_len0 = 0, ld_cnt0 = 0, fd_cnt0 = 0;
   logic [15:0] sh0 = '0;
   logic        sck0_d = 1'b0;
   always @(negedge clk) begin
      if (!rst_n || cs_n0) begin
         bits0 = 0;
         sh0   = '0;
      end else if (sck0 && !sck0_d) begin
         sh0 = {sh0[14:0], sdi0};
         bits0++;
         if (bits0 == 16) begin
            if (exp_q0.size() == 0) check("u0_unexpected_frame", 32'(exp_q0.size()), 32'd1);
            else                    check("u0_word", 32'(sh0), 32'(exp_q0.pop_front()));
            bits0 = 0;
         end
      end
      sck0_d = sck0;
      if (busy0) run0++;
      else if (run0 != 0) begin last_run0 = run0; run0 = 0; end
      if (!ld_n0) ld_len0++;
      else if (ld_len0 != 0) begin
         check("u0_ld_len", 32'(ld_len0), 32'(DIV0));
         ld_cnt0++;
         ld_len0 = 0;
      end
      if (fd0) fd_cnt0++;
   end

   // Serial capture and frame statistics, instance 1.
   int          bits1 = 0, run1 = 0, last_run1 = 0, ld_len1 = 0, ld_cnt1 = 0, fd_cnt1 = 0;
   logic [15:0] sh1 = '0;
   logic        sck1_d = 1'b0;
   always @(negedge clk) begin
      if (!rst_n || cs_n1) begin
         bits1 = 0;
         sh1   = '0;
      end else if (sck1 && !sck1_d) begin
         sh1 = {sh1[14:0], sdi1};
         bits1++;
         if (bits1 == 16) begin
            if (exp_q1.size() == 0) check("u1_unexpected_frame", 32'(exp_q1.size()), 32'd1);
            else                    check("u1_word", 32'(sh1), 32'(exp_q1.pop_front()));
            bits1 = 0;
         end
      end
      sck1_d = sck1;
      if (busy1) run1++;
      else if (run1 != 0) begin last_run1 = run1; run1 = 0; end
      if (!ld_n1) ld_len1++;
      else if (ld_len1 != 0) begin
         check("u1_ld_len", 32'(ld_len1), 32'(DIV1));
         ld_cnt1++;
         ld_len1 = 0;
      end
      if (fd1) fd_cnt1++;
   end

   task automatic drive_load(input int inst, input logic [9:0] d);
      @(negedge clk);
      if (inst == 0) begin data0 = d; load0 = 1'b1; end
      else           begin data1 = d; load1 = 1'b1; end
      @(negedge clk);
      load0 = 1'b0;
      load1 = 1'b0;
      data0 = 10'($urandom);
      data1 = 10'($urandom);
   endtask

   task automatic wait_idle(input int inst);
      int n = 0;
      while (((inst == 0) ? busy0 : busy1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("wait_idle_timeout", 32'((inst == 0) ? busy0 : busy1), 32'd0);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] d;
      int         saved_ld;
      int         n;

      rst_n = 1'b0;
      load0 = 1'b0; load1 = 1'b0;
      data0 = '0;   data1 = '0;
      repeat (3) @(negedge clk);
      check("rst_cs_n", 32'(cs_n0), 32'd1);
      check("rst_ld_n", 32'(ld_n0), 32'd1);
      check("rst_sck",  32'(sck0),  32'd0);
      check("rst_sdi",  32'(sdi0),  32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_ovr",  32'(ovr0),  32'd0);
      check("rst_fd",   32'(fd0),   32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame: first-cycle outputs, word, busy length.
      exp_q0.push_back(16'h3554);
      drive_load(0, 10'h155);
      check("start_busy", 32'(busy0), 32'd1);
      check("start_cs_n", 32'(cs_n0), 32'd0);
      check("start_sck",  32'(sck0),  32'd0);
      check("start_sdi",  32'(sdi0),  32'd0);
      wait_idle(0);
      check("busy_len_single", 32'(last_run0), 32'(34 * DIV0));

      // Full-scale then zero.
      exp_q0.push_back(16'h3FFC);
      drive_load(0, 10'h3FF);
      wait_idle(0);
      exp_q0.push_back(16'h3000);
      drive_load(0, 10'h000);
      wait_idle(0);
      check("ovr_after_idle_frames", 32'(ovr0), 32'd0);

      // Two loads during one frame: second overwrites pending, sets overrun.
      exp_q0.push_back(16'h3FFC);
      drive_load(0, 10'h3FF);
      repeat (5) @(negedge clk);
      drive_load(0, 10'h0AA);
      repeat (5) @(negedge clk);
      exp_q0.push_back(16'h3554);
      drive_load(0, 10'h155);
      check("ovr_set", 32'(ovr0), 32'd1);
      wait_idle(0);
      check("busy_len_overrun_pair", 32'(last_run0), 32'(2 * 34 * DIV0));
      check("ovr_sticky", 32'(ovr0), 32'd1);
      pulse_reset();
      check("ovr_cleared_by_reset", 32'(ovr0), 32'd0);

      // Load coincident with LATCH exit.
      exp_q0.push_back(16'h3554);
      drive_load(0, 10'h155);
      n = 0;
      while (!fd0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("fd_seen", 32'(fd0), 32'd1);
      check("fd_busy", 32'(busy0), 32'd1);
      exp_q0.push_back(model_word(10'h0F0));
      data0 = 10'h0F0;
      load0 = 1'b1;
      @(negedge clk);
      load0 = 1'b0;
      check("b2b_busy", 32'(busy0), 32'd1);
      check("b2b_cs_n", 32'(cs_n0), 32'd0);
      wait_idle(0);
      check("busy_len_b2b", 32'(last_run0), 32'(2 * 34 * DIV0));
      check("ovr_b2b", 32'(ovr0), 32'd0);

      // Reset pulse mid-SHIFT aborts the frame without a latch strobe.
      saved_ld = ld_cnt0;
      drive_load(0, 10'h155);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_cs_n", 32'(cs_n0), 32'd1);
      check("abort_sck",  32'(sck0),  32'd0);
      check("abort_busy", 32'(busy0), 32'd0);
      check("abort_ld_n", 32'(ld_n0), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("abort_stays_idle", 32'(busy0), 32'd0);
      check("abort_no_ld", 32'(ld_cnt0), 32'(saved_ld));
      exp_q0.push_back(16'h3FFC);
      drive_load(0, 10'h3FF);
      wait_idle(0);

      // Random stream at CLK_DIV=1, one load per 40 cycles.
      for (int i = 0; i < 30; i++) begin
         d = 10'($urandom);
         exp_q1.push_back(model_word(d));
         drive_load(1, d);
         repeat (38) @(negedge clk);
      end
      wait_idle(1);
      check("u1_busy_len", 32'(last_run1), 32'(34 * DIV1));
      check("u1_ovr", 32'(ovr1), 32'd0);
      check("u1_frames_ld", 32'(ld_cnt1), 32'd30);
      check("u1_frames_fd", 32'(fd_cnt1), 32'd30);
      check("u1_sb_empty", 32'(exp_q1.size()), 32'd0);

      check("u0_frames_ld", 32'(ld_cnt0), 32'd8);
      check("u0_frames_fd", 32'(fd_cnt0), 32'd8);
      check("u0_sb_empty", 32'(exp_q0.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
